// File: rtl/aqed_fc_checker.sv
// A-QED functional-consistency checker for a FIFO-mode memory core: tags an original and a
// duplicate write, captures the outputs at the matching FIFO positions and compares them.
module aqed_fc_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 17,
    parameter int BOUND      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  orig_mark,
    input  logic                  dup_mark,
    input  logic                  out_valid,
    input  logic [DATA_WIDTH-1:0] out_data,
    output logic                  orig_issued,
    output logic                  qed_done,
    output logic                  qed_check,
    output logic                  bound_err,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ORIG = 2'd1,
        S_BOTH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int                   CNT_WIDTH = $clog2(BOUND + 1);
    localparam logic [IDX_WIDTH-1:0] IDX_MAX   = {IDX_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] BOUND_CNT = CNT_WIDTH'(BOUND);

    state_t                state_reg, state_next;
    logic [IDX_WIDTH-1:0]  in_idx_reg, in_idx_next;
    logic [IDX_WIDTH-1:0]  out_idx_reg, out_idx_next;
    logic [IDX_WIDTH-1:0]  orig_idx_reg, orig_idx_next;
    logic [IDX_WIDTH-1:0]  dup_idx_reg, dup_idx_next;
    logic [DATA_WIDTH-1:0] orig_in_reg, orig_in_next;
    logic [DATA_WIDTH-1:0] dup_in_reg, dup_in_next;
    logic [DATA_WIDTH-1:0] orig_out_reg, orig_out_next;
    logic [DATA_WIDTH-1:0] dup_out_reg, dup_out_next;
    logic                  got_orig_reg, got_orig_next;
    logic                  got_dup_reg, got_dup_next;
    logic [CNT_WIDTH-1:0]  bound_cnt_reg, bound_cnt_next;
    logic                  bound_err_reg, bound_err_next;
    logic                  qed_done_reg, qed_done_next;
    logic                  qed_check_reg, qed_check_next;

    logic                  orig_accept, dup_accept;
    logic                  cap_orig, cap_dup;
    logic [IDX_WIDTH-1:0]  orig_match_idx, dup_match_idx;

    assign orig_accept = (state_reg == S_IDLE) && in_valid && orig_mark && (in_idx_reg != IDX_MAX);
    assign dup_accept  = (state_reg == S_ORIG) && in_valid && dup_mark;

    // An accept and its matching output in the same cycle compare against the index being latched.
    assign orig_match_idx = orig_accept ? in_idx_reg : orig_idx_reg;
    assign dup_match_idx  = dup_accept  ? in_idx_reg : dup_idx_reg;

    assign cap_orig = (orig_accept || state_reg == S_ORIG || state_reg == S_BOTH) &&
                      out_valid && !got_orig_reg && (out_idx_reg == orig_match_idx);
    assign cap_dup  = (dup_accept || state_reg == S_BOTH) &&
                      out_valid && !got_dup_reg && (out_idx_reg == dup_match_idx);

    always_comb begin
        state_next     = state_reg;
        in_idx_next    = in_idx_reg;
        out_idx_next   = out_idx_reg;
        orig_idx_next  = orig_idx_reg;
        dup_idx_next   = dup_idx_reg;
        orig_in_next   = orig_in_reg;
        dup_in_next    = dup_in_reg;
        orig_out_next  = orig_out_reg;
        dup_out_next   = dup_out_reg;
        got_orig_next  = got_orig_reg;
        got_dup_next   = got_dup_reg;
        bound_cnt_next = bound_cnt_reg;
        bound_err_next = bound_err_reg;
        qed_done_next  = qed_done_reg;
        qed_check_next = qed_check_reg;

        if (state_reg != S_DONE) begin
            if (in_valid && in_idx_reg != IDX_MAX) begin
                in_idx_next = in_idx_reg + IDX_WIDTH'(1);
            end
            if (out_valid && out_idx_reg != IDX_MAX) begin
                out_idx_next = out_idx_reg + IDX_WIDTH'(1);
            end
            if (orig_accept) begin
                orig_in_next   = in_data;
                orig_idx_next  = in_idx_reg;
                bound_cnt_next = '0;
                state_next     = S_ORIG;
            end
            if (dup_accept) begin
                dup_in_next  = in_data;
                dup_idx_next = in_idx_reg;
                state_next   = S_BOTH;
            end
            if (cap_orig) begin
                orig_out_next = out_data;
                got_orig_next = 1'b1;
            end
            if (cap_dup) begin
                dup_out_next = out_data;
                got_dup_next = 1'b1;
            end
            // Count the cycles after the accept in which the original output is still missing.
            if ((state_reg == S_ORIG || state_reg == S_BOTH) && !got_orig_reg && !cap_orig &&
                bound_cnt_reg != BOUND_CNT) begin
                bound_cnt_next = bound_cnt_reg + CNT_WIDTH'(1);
                if (bound_cnt_next == BOUND_CNT) begin
                    bound_err_next = 1'b1;
                end
            end
            if (got_orig_next && got_dup_next) begin
                state_next     = S_DONE;
                qed_done_next  = 1'b1;
                qed_check_next = (orig_in_next != dup_in_next) || (orig_out_next == dup_out_next);
            end
        end

        if (flush) begin
            state_next     = S_IDLE;
            in_idx_next    = '0;
            out_idx_next   = '0;
            orig_idx_next  = '0;
            dup_idx_next   = '0;
            orig_in_next   = '0;
            dup_in_next    = '0;
            orig_out_next  = '0;
            dup_out_next   = '0;
            got_orig_next  = 1'b0;
            got_dup_next   = 1'b0;
            bound_cnt_next = '0;
            bound_err_next = 1'b0;
            qed_done_next  = 1'b0;
            qed_check_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            in_idx_reg    <= '0;
            out_idx_reg   <= '0;
            orig_idx_reg  <= '0;
            dup_idx_reg   <= '0;
            orig_in_reg   <= '0;
            dup_in_reg    <= '0;
            orig_out_reg  <= '0;
            dup_out_reg   <= '0;
            got_orig_reg  <= 1'b0;
            got_dup_reg   <= 1'b0;
            bound_cnt_reg <= '0;
            bound_err_reg <= 1'b0;
            qed_done_reg  <= 1'b0;
            qed_check_reg <= 1'b1;
        end else if (clk_en) begin
            state_reg     <= state_next;
            in_idx_reg    <= in_idx_next;
            out_idx_reg   <= out_idx_next;
            orig_idx_reg  <= orig_idx_next;
            dup_idx_reg   <= dup_idx_next;
            orig_in_reg   <= orig_in_next;
            dup_in_reg    <= dup_in_next;
            orig_out_reg  <= orig_out_next;
            dup_out_reg   <= dup_out_next;
            got_orig_reg  <= got_orig_next;
            got_dup_reg   <= got_dup_next;
            bound_cnt_reg <= bound_cnt_next;
            bound_err_reg <= bound_err_next;
            qed_done_reg  <= qed_done_next;
            qed_check_reg <= qed_check_next;
        end
    end

    assign orig_issued = (state_reg != S_IDLE);
    assign qed_done    = qed_done_reg;
    assign qed_check   = qed_check_reg;
    assign bound_err   = bound_err_reg;
    assign state       = state_reg;

endmodule

// File: doc/aqed_fc_checker.md
# aqed_fc_checker

- Downstream A-QED functional-consistency checker for the memory core in FIFO mode.
- Watches every element written into the core and every element it returns. It tags one "original" write and one later "duplicate" write, then captures the core's outputs at the matching FIFO positions.
- Once both outputs are captured, it flags `qed_done` and reports whether equal inputs produced equal outputs.
- It also raises a sticky error if the original's output does not appear within a bounded number of cycles.

## Interface

Parameters:

- DATA_WIDTH, 16, width of stored and returned elements
- IDX_WIDTH, 17, width of the input and output position counters
- BOUND, 64, maximum clk_en cycles allowed from original accept to original output

Ports:

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  gates every state update; when low all registers hold
- flush  in  1  synchronous clear to IDLE (takes effect only when clk_en=1)
- in_valid  in  1  element accepted by memory core this cycle
- in_data  in  DATA_WIDTH  element written
- orig_mark  in  1  qualifies this in_valid as the original candidate
- dup_mark  in  1  qualifies this in_valid as the duplicate candidate
- out_valid  in  1  memory core returns an element this cycle
- out_data  in  DATA_WIDTH  returned element
- orig_issued  out  1  original accepted (state ≠ IDLE)
- qed_done  out  1  both outputs captured; sticky
- qed_check  out  1  consistency result; meaningful when qed_done=1
- bound_err  out  1  original output overdue; sticky
- state  out  2  IDLE=0, ORIG=1, BOTH=2, DONE=3

## Operation

- `in_idx` increments on every in_valid; `out_idx` increments on every out_valid. Both saturate at 2^IDX_WIDTH−1 and never wrap.
- IDLE:
  - in_valid & orig_mark & `in_idx` not saturated → latch orig_in=in_data and orig_idx=in_idx, then go to ORIG.
  - dup_mark is ignored in IDLE. If orig_mark and dup_mark are both high, only the original is taken.
- ORIG:
  - in_valid & dup_mark → latch dup_in and dup_idx=in_idx, then go to BOTH.
  - orig_mark is ignored from ORIG onward.
- Output capture (ORIG or BOTH):
  - out_valid & out_idx==orig_idx & !got_orig → latch orig_out and set got_orig.
  - The same rule applies to dup_idx, dup_out and got_dup.
  - Same-cycle case: an accept and a matching output in the same cycle compare against the in_idx value being latched, so the output is captured.
- BOTH → DONE when got_orig & got_dup. The transition may happen in the cycle the second capture occurs, so DONE is registered one cycle after that output.
- In DONE:
  - qed_done=1.
  - qed_check = (orig_in ≠ dup_in) | (orig_out == dup_out).
  - All inputs are ignored until reset or flush.
- Bound counter:
  - Clears on the original accept and increments each clk_en cycle while !got_orig.
  - On reaching BOUND, bound_err=1 (sticky).
  - The counter saturates at BOUND.
- Flush or reset clears all registers, counters, got flags and outputs to their reset values.

## Timing

- Reset values: orig_issued=0, qed_done=0, qed_check=1, bound_err=0, state=IDLE, all counters 0.
- orig_issued is high in the cycle after the original accept.
- qed_done and qed_check are high in the cycle after the second required capture, and are updated together.
- bound_err is high in the cycle after the BOUND-th clk_en cycle with no original output.
- clk_en=0 freezes all state, counters and the bound count; outputs hold.
- Asynchronous reset asserted mid-operation forces reset values immediately. The block restarts in IDLE on the first clk edge after deassertion.
- Flush and a capture in the same cycle: flush wins.

## Test plan

- Orig 0x00A5 at position 2, dup 0x00A5 at position 5; outputs 0x00A5 at out positions 2 and 5 → qed_done=1 and qed_check=1 one cycle after the 6th output.
- Same inputs, but out position 5 returns 0x00A4 → qed_done=1, qed_check=0.
- Orig 0x0001, dup 0x0002, outputs differ → qed_check=1, since the inputs differ.
- Orig accepted and no out_valid for 64 clk_en cycles with BOUND=64 → bound_err=1 on cycle 65, with qed_done=0.
- orig_mark and dup_mark both high in IDLE at position 0; dup marked at position 3 → orig_idx=0, dup_idx=3, and the first dup_mark is ignored.
- Reset pulled low in BOTH, and clk_en toggled low for 3 cycles mid-run → outputs return to reset values instantly; counters frozen while clk_en=0.
